// File: rtl/seq_normalizer_if.sv
// Handshake and result bundle for seq_normalizer: a request side (start/A/mode)
// and a result side (busy/done/res/cnt/zero).
interface seq_normalizer_if #(
  parameter int N = 8
);
  localparam int CW = $clog2(N) + 1;

  logic          start;
  logic [N-1:0]  A;
  logic          mode;
  logic          busy;
  logic          done;
  logic [N-1:0]  res;
  logic [CW-1:0] cnt;
  logic          zero;

  modport master (
    output start, A, mode,
    input  busy, done, res, cnt, zero
  );

  modport slave (
    input  start, A, mode,
    output busy, done, res, cnt, zero
  );
endinterface

// File: rtl/seq_normalizer.sv
// Sequential normalizer: shifts the captured operand one bit per cycle until the
// leading (mode 0) or trailing (mode 1) bit is set, reporting the shift count.
module seq_normalizer #(
  parameter int N = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_normalizer_if.slave bus
);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_r;
  logic [N-1:0]  work_r;
  logic          mode_r;
  logic [CW-1:0] count_r;
  logic [N-1:0]  res_r;
  logic [CW-1:0] cnt_r;
  logic          zero_r;
  logic          busy_r;
  logic          done_r;
  logic          target_s;

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.res  = res_r;
  assign bus.cnt  = cnt_r;
  assign bus.zero = zero_r;

  // Bit that ends the search: MSB for left-normalize, LSB for right-normalize.
  always_comb begin
    target_s = 1'b0;
    if (mode_r) begin
      target_s = work_r[0];
    end else begin
      target_s = work_r[N-1];
    end
  end

  // Control FSM with registered busy/done and result registers.
  // done is raised on leaving DONE so it appears one cycle after the result
  // registers load; a start seen while done is high is still part of the
  // finishing operation and is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      work_r  <= {N{1'b0}};
      mode_r  <= 1'b0;
      count_r <= {CW{1'b0}};
      res_r   <= {N{1'b0}};
      cnt_r   <= {CW{1'b0}};
      zero_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start && !done_r) begin
            work_r  <= bus.A;
            mode_r  <= bus.mode;
            count_r <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= SHIFT;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          busy_r <= 1'b1;
          done_r <= 1'b0;
          if (work_r == {N{1'b0}}) begin
            res_r   <= {N{1'b0}};
            cnt_r   <= CW'(N);
            zero_r  <= 1'b1;
            state_r <= DONE;
          end else if (target_s) begin
            res_r   <= work_r;
            cnt_r   <= count_r;
            zero_r  <= 1'b0;
            state_r <= DONE;
          end else begin
            if (mode_r) begin
              work_r <= work_r >> 1;
            end else begin
              work_r <= work_r << 1;
            end
            count_r <= count_r + CW'(1);
            state_r <= SHIFT;
          end
        end
        DONE: begin
          busy_r  <= 1'b1;
          done_r  <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_normalizer.sv
// Self-checking bench for seq_normalizer (N=8): directed corner cases plus
// randomized operands against a bit-scanning reference model.
module tb_seq_normalizer;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  seq_normalizer_if #(.N(8)) bus();

  seq_normalizer #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: count zeros from the target end, shift the operand by that much.
  task automatic model(input logic [7:0] a, input logic m,
                       output logic [7:0] eres, output logic [3:0] ecnt,
                       output logic ez, output int eedge);
    int k;
    k = 0;
    if (a == 8'h00) begin
      eres = 8'h00; ecnt = 4'd8; ez = 1'b1; eedge = 2;
    end else begin
      while (k < 8 && !(m ? a[k] : a[7-k])) k++;
      eres = m ? (a >> k) : (a << k);
      ecnt = 4'(k);
      ez = 1'b0;
      eedge = k + 2;
    end
  endtask

  // Called at a negedge; returns at a negedge in the first idle cycle after done.
  task automatic do_op(input logic [7:0] a, input logic m, input bit poke);
    logic [7:0] eres;
    logic [3:0] ecnt;
    logic       ez;
    int         eedge;
    model(a, m, eres, ecnt, ez, eedge);
    bus.start = 1'b1; bus.A = a; bus.mode = m;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0; bus.A = 8'($urandom); bus.mode = 1'($urandom);
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL accept a=%h m=%b: busy=%b done=%b, want busy=1 done=0", a, m, bus.busy, bus.done);
    end
    for (int e = 1; e <= eedge; e++) begin
      @(posedge clk); @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if (bus.done !== (e == eedge)) begin
        errors++;
        $display("FAIL done_timing a=%h m=%b edge=%0d: done=%b want %b", a, m, e, bus.done, (e == eedge));
      end
      checks++;
      if (bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL busy a=%h m=%b edge=%0d: busy=%b want 1", a, m, e, bus.busy);
      end
      if (poke && e == 2) begin
        bus.start = 1'b1; bus.A = 8'hFF; bus.mode = 1'b0;
      end
      if (e == eedge) begin
        checks++;
        if (bus.res !== eres || bus.cnt !== ecnt || bus.zero !== ez) begin
          errors++;
          $display("FAIL result a=%h m=%b: res=%h cnt=%0d zero=%b want res=%h cnt=%0d zero=%b",
                   a, m, bus.res, bus.cnt, bus.zero, eres, ecnt, ez);
        end
        bus.start = 1'b1; bus.A = 8'($urandom); bus.mode = 1'($urandom);
      end
    end
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle_start a=%h: busy=%b done=%b want 0 0", a, bus.busy, bus.done);
    end
    checks++;
    if (bus.res !== eres || bus.cnt !== ecnt || bus.zero !== ez) begin
      errors++;
      $display("FAIL hold a=%h m=%b: res=%h cnt=%0d zero=%b want res=%h cnt=%0d zero=%b",
               a, m, bus.res, bus.cnt, bus.zero, eres, ecnt, ez);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.start = 1'b0; bus.A = 8'h00; bus.mode = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.res, bus.cnt, bus.zero} !== 15'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b res=%h cnt=%0d zero=%b want all 0",
               bus.busy, bus.done, bus.res, bus.cnt, bus.zero);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    do_op(8'b0001_0110, 1'b0, 1'b0);
    do_op(8'h80, 1'b0, 1'b0);
    do_op(8'h01, 1'b0, 1'b0);
    do_op(8'h00, 1'b0, 1'b0);
    do_op(8'h00, 1'b1, 1'b0);
    do_op(8'b0110_1000, 1'b1, 1'b0);
    do_op(8'h80, 1'b1, 1'b0);
    do_op(8'h01, 1'b1, 1'b0);
  endtask

  task automatic test_start_while_busy();
    do_op(8'h01, 1'b0, 1'b1);
  endtask

  task automatic test_reset_midop();
    bit saw_done;
    bus.start = 1'b1; bus.A = 8'h01; bus.mode = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.res, bus.cnt, bus.zero} !== 15'd0) begin
      errors++;
      $display("FAIL midop_reset: busy=%b done=%b res=%h cnt=%0d zero=%b want all 0",
               bus.busy, bus.done, bus.res, bus.cnt, bus.zero);
    end
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (10) begin
      @(posedge clk); @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abandoned_op: saw done/busy after reset, want none");
    end
    do_op(8'h40, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] a;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      if ($urandom_range(0, 7) == 0) a = 8'h00;
      else if ($urandom_range(0, 3) == 0) a = 8'h01 << $urandom_range(0, 7);
      do_op(a, 1'($urandom), 1'b0);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_directed();
    test_start_while_busy();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_normalizer.md
SEQ_NORMALIZER -- requirements
Module: seq_normalizer

Interface
REQ-001 SHALL have parameter N, default 8, meaning operand/result width in bits (power of two, >= 4).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request to normalize A; sampled only in IDLE.
REQ-005 SHALL have port A  input  N  operand, captured on the accepted start edge.
REQ-006 SHALL have port mode  input  1  direction, captured with A: 0 = left-normalize (leading zeros), 1 = right-normalize (trailing zeros).
REQ-007 SHALL have port busy  output  1  high in SHIFT and DONE states.
REQ-008 SHALL have port done  output  1  one-cycle pulse; res/cnt/zero are valid from this cycle on.
REQ-009 SHALL have port res  output  N  normalized operand.
REQ-010 SHALL have port cnt  output  $clog2(N)+1  number of positions shifted (shift amount recovered from A).
REQ-011 SHALL have port zero  output  1  high when the captured A was all zeros.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 IDLE: start=1 -> load working register with A, latch mode, clear count, go to SHIFT; start=0 -> stay in IDLE.
REQ-014 SHIFT, working register all zeros: res=0, cnt=N, zero=1, go to DONE.
REQ-015 SHIFT, target bit set (bit N-1 if mode=0, bit 0 if mode=1): res=working register, cnt=count, zero=0, go to DONE.
REQ-016 SHIFT, otherwise: shift working register one position (mode 0: left, zero fill; mode 1: right logical, zero fill), count+1, stay in SHIFT.
REQ-017 DONE: done=1 for exactly this cycle, then IDLE unconditionally.
REQ-018 Latency: for nonzero A, done SHALL be high in the cycle that begins (cnt+2) rising edges after the accepted start edge; for A=0, after 2 edges.
REQ-019 Nonzero A SHALL give cnt in 0..N-1; A=0 is the only case giving cnt=N.
REQ-020 start while busy SHALL be ignored with no effect on state, operand or outputs; A/mode changes after capture SHALL have no effect.
REQ-021 res, cnt and zero SHALL change only on the SHIFT->DONE transition and SHALL hold until the next result or reset.
REQ-022 start asserted in the DONE cycle SHALL be ignored; a start in the following IDLE cycle SHALL be accepted.
REQ-023 Invariant: for nonzero A, mode 0: res == A << cnt with res[N-1]=1; mode 1: res == A >> cnt with res[0]=1.

Reset
REQ-024 rst_n=0 at a rising edge SHALL force IDLE and set busy=0, done=0, res=0, cnt=0, zero=0, clear working register and count, overriding any other activity.
REQ-025 Reset during SHIFT or DONE SHALL abandon the operation with no done pulse; the first start after rst_n returns high SHALL be accepted normally.

Verification (N=8; cycle numbers count edges after the start edge)
REQ-026 A=8'b0001_0110, mode=0 -> done at edge 5, res=8'b1011_0000, cnt=3, zero=0.
REQ-027 A=8'h80, mode=0 -> done at edge 2, res=8'h80, cnt=0; A=8'h01, mode=0 -> done at edge 9, res=8'h80, cnt=7.
REQ-028 A=8'h00, either mode -> done at edge 2, res=8'h00, cnt=8, zero=1.
REQ-029 A=8'b0110_1000, mode=1 -> done at edge 5, res=8'b0000_1101, cnt=3.
REQ-030 Start A=8'h01 mode=0, then start with A=8'hFF at edge 3 -> ignored; result res=8'h80, cnt=7 at edge 9; start in the DONE cycle also ignored.
REQ-031 Start A=8'h01, rst_n=0 at edge 4 -> all outputs 0 at the next edge, no done pulse; then A=8'h40 mode=0 -> res=8'h80, cnt=1 at edge 3.
